// File: rtl/param_bus_follower.sv
// Parameterised bus follower: receives a multi-phase address, then serves
// read or write bursts against an internal word memory over a tri-state data bus.
module param_bus_follower #(
  parameter int DW     = 8,
  parameter int BW     = 8,
  parameter int ADDR_W = 16,
  parameter int WAIT   = 2,
  parameter int LW     = 2
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic          start,
  input  logic          read,
  input  logic [LW-1:0] burstLen,
  input  logic [BW-1:0] address,
  inout  wire  [DW-1:0] data,
  inout  wire           dataValid,
  output logic          busy
);

  localparam int NPH = ADDR_W / BW;
  localparam int PCW = (NPH > 2) ? $clog2(NPH - 1) : 1;
  localparam int WCW = (WAIT > 2) ? $clog2(WAIT) : 1;
  localparam logic [PCW-1:0] LAST_PH   = PCW'((NPH > 1) ? NPH - 2 : 0);
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((WAIT > 0) ? WAIT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RWAIT,
    S_RDATA,
    S_WDATA
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_read;
  logic [LW-1:0]     r_beats;
  logic [WCW-1:0]    r_wait;
  logic [PCW-1:0]    r_phase;
  int                w_lsb;
  logic              w_wr;
  logic [DW-1:0]     w_rd_data;

  // Memory powers up cleared and is deliberately left out of the reset domain.
  bit   [DW-1:0]     r_mem [2**ADDR_W];

  function automatic state_t data_state(input logic rd);
    if (!rd) return S_WDATA;
    return (WAIT > 0) ? S_RWAIT : S_RDATA;
  endfunction

  assign w_wr      = (r_state == S_WDATA) && (dataValid == 1'b1);
  assign w_rd_data = r_mem[r_addr];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_lsb  = ADDR_W - BW * (int'(r_phase) + 2);
    case (r_state)
      S_IDLE:  if (start) w_next = (NPH > 1) ? S_ADDR : data_state(read);
      S_ADDR:  if (r_phase == LAST_PH) w_next = data_state(r_read);
      S_RWAIT: if (r_wait == '0) w_next = S_RDATA;
      S_RDATA: begin
        if (r_beats != '0) w_next = (WAIT > 0) ? S_RWAIT : S_RDATA;
        else               w_next = S_IDLE;
      end
      S_WDATA: if (w_wr && (r_beats == '0)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_beats <= '0;
      r_wait  <= '0;
      r_phase <= '0;
    end else begin
      // Reload on every entry to RWAIT, including between burst beats.
      if ((w_next == S_RWAIT) && (r_state != S_RWAIT)) r_wait <= WAIT_LOAD;
      else if ((r_state == S_RWAIT) && (r_wait != '0)) r_wait <= r_wait - 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= ADDR_W'(address) << (ADDR_W - BW);
            r_read  <= read;
            r_beats <= burstLen;
            r_phase <= '0;
          end
        end
        S_ADDR: begin
          r_addr[w_lsb +: BW] <= address;
          r_phase             <= r_phase + 1'b1;
        end
        S_RDATA: begin
          if (r_beats != '0) begin
            r_beats <= r_beats - 1'b1;
            r_addr  <= r_addr + 1'b1;
          end
        end
        S_WDATA: begin
          if (w_wr && (r_beats != '0)) begin
            r_beats <= r_beats - 1'b1;
            r_addr  <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_addr] <= data;
  end

  assign busy      = (r_state != S_IDLE);
  assign data      = (r_state == S_RDATA) ? w_rd_data : {DW{1'bz}};
  assign dataValid = ((r_state == S_RDATA) || (r_state == S_RWAIT)) ? (r_state == S_RDATA) : 1'bz;

endmodule

// File: doc/param_bus_follower.md
PARAM_BUS_FOLLOWER -- requirements
Module: param_bus_follower

Interface
REQ-001 SHALL have parameter DW, default 8: width of the data bus and of each memory word.
REQ-002 SHALL have parameter BW, default 8: width of the bus address lines carrying one address chunk per cycle.
REQ-003 SHALL have parameter ADDR_W, default 16: memory address width, multiple of BW; depth is 2**ADDR_W words; NPH = ADDR_W/BW address phases.
REQ-004 SHALL have parameter WAIT, default 2: read wait cycles before every read beat (0 allowed).
REQ-005 SHALL have parameter LW, default 2: width of burstLen; a burst carries burstLen+1 beats.
REQ-006 clock  input  1  single clock, all state changes on rising edge.
REQ-007 resetN  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  leader request, valid in IDLE only.
REQ-009 read  input  1  1=read, 0=write; sampled with start.
REQ-010 burstLen  input  LW  beats minus one; sampled with start.
REQ-011 address  input  BW  address chunk, most significant chunk first.
REQ-012 data  inout  DW  tri-state; driven by this block only in RDATA.
REQ-013 dataValid  inout  1  tri-state; driven by this block in RWAIT (0) and RDATA (1), by the leader otherwise.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, ADDR, RWAIT, RDATA, WDATA.
REQ-016 IDLE with start=1 at a rising edge SHALL capture address as AddrReg[ADDR_W-1:ADDR_W-BW], read and burstLen, load beat count = burstLen, and go to ADDR (NPH>1) or to the data decision (NPH=1).
REQ-017 ADDR SHALL capture one further chunk per cycle into the next-lower BW bits, lowest chunk last, NPH-1 cycles total.
REQ-018 After the last address phase, read=1 SHALL go to RWAIT (or RDATA directly if WAIT=0), read=0 SHALL go to WDATA.
REQ-019 RWAIT SHALL last exactly WAIT cycles, counted by an internal down-counter.
REQ-020 RDATA SHALL last exactly one cycle, driving data=Mem[AddrReg] and dataValid=1; first read beat appears NPH+WAIT cycles after the start cycle.
REQ-021 After RDATA, if beat count is non-zero, SHALL decrement it, increment AddrReg and return to RWAIT (or RDATA if WAIT=0); otherwise return to IDLE.
REQ-022 WDATA SHALL, on each rising edge with dataValid=1, write data into Mem[AddrReg]; on the last beat go to IDLE, else decrement beat count, increment AddrReg and remain in WDATA.
REQ-023 WDATA with dataValid=0 SHALL stall indefinitely without memory change.
REQ-024 AddrReg increment SHALL wrap modulo 2**ADDR_W (all-ones -> 0).
REQ-025 start asserted outside IDLE SHALL be ignored.
REQ-026 data and dataValid SHALL be high-Z in IDLE, ADDR and WDATA; data SHALL be high-Z in RWAIT.
REQ-027 A read following a write to the same address SHALL return the written value.

Reset
REQ-028 resetN low SHALL immediately force IDLE, busy=0, data and dataValid high-Z, beat and wait counters 0.
REQ-029 Reset mid-transaction SHALL abandon it; the next start after resetN rises SHALL be served normally.
REQ-030 Memory contents SHALL be zero at simulation start and SHALL NOT be altered by reset.

Verification (DW=8, BW=8, ADDR_W=16, WAIT=2, LW=2)
REQ-031 Single write 0x0406<=0xDC, then single read 0x0406 -> dataValid=1, data=0xDC exactly 4 cycles after read start cycle, busy low next cycle.
REQ-032 Burst write burstLen=3 at 0x00FE with 0x11,0x22,0x33,0x44; burst read same -> addresses 0x00FE,0x00FF,0x0100,0x0101 return 0x11..0x44, beats 3 cycles apart.
REQ-033 Burst read burstLen=1 at 0xFFFF after writing 0xAA@0xFFFF, 0x55@0x0000 -> beats 0xAA then 0x55 (wrap).
REQ-034 resetN low during RWAIT of a read -> data/dataValid high-Z and busy=0 same instant; subsequent read of 0x0406 returns 0xDC.
REQ-035 start pulsed during WDATA of a write -> ignored; only original burst completes; write with dataValid held low 10 cycles -> memory unchanged, busy stays 1.
